keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Sequential scan controller for the 3x3 key matrix whose row/column codes are produced by the combinational encoders. It drives one matrix column at a time and samples the three row sense lines. It debounces press and release, then delivers one (row, col) key event per physical press through a one-entry valid/ready output register. It also flags events lost to a stalled consumer.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to accept a press or a release (legal range 1..255).
- `SCAN_DWELL`, default 2: cycles each column is driven before its rows are sampled (legal range 1..15).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable.
- `row_in` in 3: row sense for the currently driven column, active-high, already synchronised.
- `col_drv` out 3: one-hot column drive, active-high.
- `key_valid` out 1: key event pending.
- `key_row` out 2: row code, 1..3 = row 0..2, 0 = none.
- `key_col` out 2: column code, 1..3 = column 0..2, 0 = none.
- `key_ready` in 1: consumer accepts the event.
- `overrun` out 1: sticky, an event was dropped.
- `ovr_clr` in 1: clears `overrun`.

## Operation
- States: IDLE, SCAN, DEB_PRESS, PRESSED, DEB_REL.
- **IDLE**: `col_drv=000`. When `en=1`, go to SCAN with column index 0 and dwell counter 0.
- **SCAN**: `col_drv` is one-hot of the column index.
  - Dwell counter counts 0..SCAN_DWELL-1. `row_in` is sampled on the last dwell cycle.
  - If the sample is 000, advance the column index (wrap 2 to 0) and restart the dwell.
  - If the sample is nonzero, snapshot it, clear the debounce counter and go to DEB_PRESS.
- **DEB_PRESS**: column held.
  - Each cycle, `row_in==snapshot` increments the counter.
  - Any mismatch returns to SCAN on the same column with the dwell restarted.
  - When the counter reaches DEBOUNCE_CYCLES, go to PRESSED and generate the event.
- **Event generation**:
  - Row code = priority encode of {snapshot, 1'b0}; the highest set row wins.
  - Column code = column index + 1.
- **PRESSED**: column held. When `row_in==000`, clear the counter and go to DEB_REL.
- **DEB_REL**:
  - Each cycle with `row_in==000` increments the counter.
  - Any nonzero sample returns to PRESSED with no new event.
  - When the counter reaches DEBOUNCE_CYCLES, go to SCAN on the next column (wrap).
- **Output register**:
  - On an event with `key_valid=0`, or with `key_valid&key_ready` in the same cycle: load `key_row`/`key_col` and hold `key_valid=1`.
  - On an event with `key_valid=1 & key_ready=0`: drop the event and set `overrun`. The held data is unchanged.
  - `key_valid&key_ready` with no event: clear `key_valid` and zero the codes.
  - Data is stable while `key_valid=1`.
- `overrun`: set has priority over `ovr_clr` in the same cycle.
- `en` deasserted in any state: next state is IDLE and `col_drv=000`. The output register and `overrun` are unaffected; a pending event remains deliverable.

## Timing
- Reset (async assert, sync release): state IDLE, all counters 0, `col_drv=000`, `key_valid=0`, `key_row=00`, `key_col=00`, `overrun=0`.
- `rst_n` low mid-debounce or mid-handshake discards everything immediately, including any pending event.
- `col_drv` is registered and changes on the clock edge that advances the column.
- `row_in` is sampled in the same cycles as the `col_drv` value it corresponds to.
- Press latency: sample at edge t, then DEB_PRESS counts at edges t+1..t+D, giving `key_valid`=1 and PRESSED after edge t+D.
- Release: D consecutive zero samples, then the next column is driven after the following edge.
- Full scan period with no key: 3·SCAN_DWELL cycles.
- Simultaneous keys in different columns: only the first column scanned is reported. Other columns are ignored until its release completes.

## Structure
- Package `keypad_pkg`:
  - state enum (5 states);
  - `KP_ROWS=3`, `KP_COLS=3`;
  - `CODE_NONE=2'd0`.
- Reuse the existing 4-input `priority_encoder` as the one sub-module for the row code. Everything else is flat in `keypad_scan_ctrl`.

## Test plan
- Reset with `en=1`, no keys: `col_drv` cycles 001, 010, 100, 001 every 2 cycles; `key_valid` stays 0.
- Press row1/col2 stable (`row_in=010` while `col_drv=100`): `key_valid=1`, `key_row=2`, `key_col=3` exactly 4 cycles after the sample; held until `key_ready`; cleared the cycle after the accept; after release + 4 cycles, `col_drv=001`.
- Bounce: `row_in` 010 then 000 after 2 DEB_PRESS cycles: no event, column re-dwells; a later stable press reports exactly one event.
- Rows 001 and 100 pressed together in column 0: `key_row=3`, `key_col=1`.
- Two presses with `key_ready=0`: first event held, `overrun=1`, data unchanged. Pulse `ovr_clr` then `overrun=0`; `key_ready` then delivers the first event only.
- Drop `en` mid-DEB_PRESS: `col_drv=000` next cycle and pending output retained. Assert `rst_n=0` with `key_valid=1`: all outputs 0 immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, sizes and small helpers for the 3x3 keypad scan controller.
package keypad_pkg;

  localparam int         KP_ROWS   = 3;
  localparam int         KP_COLS   = 3;
  localparam logic [1:0] CODE_NONE = 2'd0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    DEB_PRESS = 3'd2,
    PRESSED   = 3'd3,
    DEB_REL   = 3'd4
  } kp_state_e;

  // Next column index with wrap from the last column back to column 0.
  function automatic logic [1:0] next_col(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // One-hot column drive pattern for a column index; illegal index drives nothing.
  function automatic logic [KP_COLS-1:0] col_onehot(input logic [1:0] idx);
    logic [KP_COLS-1:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_prio_enc.sv
// 4-input priority encoder: index of the highest set request bit, 0 when none.
module priority_encoder (
  input  logic [3:0] req,
  output logic [1:0] code
);

  // Highest set bit wins.
  always_comb begin
    code = 2'd0;
    if (req[3]) begin
      code = 2'd3;
    end else if (req[2]) begin
      code = 2'd2;
    end else if (req[1]) begin
      code = 2'd1;
    end else begin
      code = 2'd0;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning 3x3 keypad controller with press/release debounce, a one-entry
// valid/ready event register and a sticky overrun flag for dropped events.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_DWELL      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [KP_ROWS-1:0] row_in,
  output logic [KP_COLS-1:0] col_drv,
  output logic               key_valid,
  output logic [1:0]         key_row,
  output logic [1:0]         key_col,
  input  logic               key_ready,
  output logic               overrun,
  input  logic               ovr_clr
);

  localparam logic [3:0] DWELL_LAST = 4'(SCAN_DWELL - 1);
  localparam logic [7:0] DEB_TGT    = 8'(DEBOUNCE_CYCLES);

  kp_state_e          state_r, state_nx_s;
  logic [1:0]         col_idx_r, col_nx_s;
  logic [3:0]         dwell_r, dwell_nx_s;
  logic [7:0]         deb_r, deb_nx_s, deb_inc_s;
  logic [KP_ROWS-1:0] snap_r, snap_nx_s;
  logic               event_s;
  logic [1:0]         row_code_s;
  logic [KP_COLS-1:0] col_drv_r;
  logic               key_valid_r, overrun_r;
  logic [1:0]         key_row_r, key_col_r;

  assign deb_inc_s = deb_r + 8'd1;

  // Row code from the snapshot; the shift makes row 0 map to code 1.
  priority_encoder u_row_enc (
    .req  ({snap_r, 1'b0}),
    .code (row_code_s)
  );

  // Next-state logic for scan, debounce and release tracking.
  always_comb begin
    state_nx_s = state_r;
    col_nx_s   = col_idx_r;
    dwell_nx_s = dwell_r;
    deb_nx_s   = deb_r;
    snap_nx_s  = snap_r;
    event_s    = 1'b0;
    if (!en) begin
      state_nx_s = IDLE;
      dwell_nx_s = 4'd0;
      deb_nx_s   = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nx_s = SCAN;
          col_nx_s   = 2'd0;
          dwell_nx_s = 4'd0;
        end
        SCAN: begin
          if (dwell_r == DWELL_LAST) begin
            dwell_nx_s = 4'd0;
            if (row_in == 3'b000) begin
              col_nx_s = next_col(col_idx_r);
            end else begin
              snap_nx_s  = row_in;
              deb_nx_s   = 8'd0;
              state_nx_s = DEB_PRESS;
            end
          end else begin
            dwell_nx_s = dwell_r + 4'd1;
          end
        end
        DEB_PRESS: begin
          if (row_in == snap_r) begin
            deb_nx_s = deb_inc_s;
            if (deb_inc_s == DEB_TGT) begin
              state_nx_s = PRESSED;
              event_s    = 1'b1;
            end else begin
              state_nx_s = DEB_PRESS;
            end
          end else begin
            state_nx_s = SCAN;
            dwell_nx_s = 4'd0;
          end
        end
        PRESSED: begin
          if (row_in == 3'b000) begin
            deb_nx_s   = 8'd0;
            state_nx_s = DEB_REL;
          end else begin
            state_nx_s = PRESSED;
          end
        end
        DEB_REL: begin
          if (row_in == 3'b000) begin
            deb_nx_s = deb_inc_s;
            if (deb_inc_s == DEB_TGT) begin
              state_nx_s = SCAN;
              col_nx_s   = next_col(col_idx_r);
              dwell_nx_s = 4'd0;
            end else begin
              state_nx_s = DEB_REL;
            end
          end else begin
            state_nx_s = PRESSED;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // Scan state, counters, snapshot and registered column drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      col_idx_r <= 2'd0;
      dwell_r   <= 4'd0;
      deb_r     <= 8'd0;
      snap_r    <= 3'b000;
      col_drv_r <= 3'b000;
    end else begin
      state_r   <= state_nx_s;
      col_idx_r <= col_nx_s;
      dwell_r   <= dwell_nx_s;
      deb_r     <= deb_nx_s;
      snap_r    <= snap_nx_s;
      col_drv_r <= (state_nx_s == IDLE) ? 3'b000 : col_onehot(col_nx_s);
    end
  end

  // One-entry event register: load when empty or draining, drop when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r <= 1'b0;
      key_row_r   <= CODE_NONE;
      key_col_r   <= CODE_NONE;
    end else if (event_s && (!key_valid_r || key_ready)) begin
      key_valid_r <= 1'b1;
      key_row_r   <= row_code_s;
      key_col_r   <= col_idx_r + 2'd1;
    end else if (!event_s && key_valid_r && key_ready) begin
      key_valid_r <= 1'b0;
      key_row_r   <= CODE_NONE;
      key_col_r   <= CODE_NONE;
    end else begin
      key_valid_r <= key_valid_r;
      key_row_r   <= key_row_r;
      key_col_r   <= key_col_r;
    end
  end

  // Sticky overrun: a dropped event outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (event_s && key_valid_r && !key_ready) begin
      overrun_r <= 1'b1;
    end else if (ovr_clr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign col_drv   = col_drv_r;
  assign key_valid = key_valid_r;
  assign key_row   = key_row_r;
  assign key_col   = key_col_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed testbench for keypad_scan_ctrl with default DEBOUNCE_CYCLES=4, SCAN_DWELL=2.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, key_ready, ovr_clr;
  logic [2:0] row_in;
  logic [2:0] col_drv;
  logic       key_valid, overrun;
  logic [1:0] key_row, key_col;
  int         tests_run = 0;
  int         tests_failed = 0;

  keypad_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .row_in    (row_in),
    .col_drv   (col_drv),
    .key_valid (key_valid),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_ready (key_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until col_drv has just switched to target (dwell restarted).
  task automatic wait_col(input logic [2:0] target);
    logic [2:0] prev;
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = col_drv;
      @(negedge clk);
      if (prev !== target && col_drv === target) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      $display("FAIL wait_col: col_drv=%b never entered %b", col_drv, target);
      tests_failed++;
    end
  endtask

  task automatic test_reset();
    logic [2:0] exp_tbl [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    rst_n = 1'b0; en = 1'b1; row_in = 3'b000; key_ready = 1'b0; ovr_clr = 1'b0;
    step(2);
    tests_run++;
    if ({col_drv, key_valid, key_row, key_col, overrun} !== 9'd0) begin
      $display("FAIL reset_state: got col/v/r/c/o=%b/%b/%0d/%0d/%b want all 0",
               col_drv, key_valid, key_row, key_col, overrun);
      tests_failed++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      tests_run++;
      if (col_drv !== exp_tbl[i] || key_valid !== 1'b0) begin
        $display("FAIL idle_scan[%0d]: got col=%b v=%b want col=%b v=0", i, col_drv, key_valid, exp_tbl[i]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_press();
    bit early = 1'b0;
    wait_col(3'b100);
    row_in = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (key_valid !== 1'b0) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      $display("FAIL press_latency: key_valid rose before edge t+4");
      tests_failed++;
    end
    step(1);
    tests_run++;
    if ({key_valid, key_row, key_col, col_drv} !== {1'b1, 2'd2, 2'd3, 3'b100}) begin
      $display("FAIL press_event: got v/r/c/col=%b/%0d/%0d/%b want 1/2/3/100", key_valid, key_row, key_col, col_drv);
      tests_failed++;
    end
    step(3);
    tests_run++;
    if ({key_valid, key_row, key_col} !== {1'b1, 2'd2, 2'd3}) begin
      $display("FAIL press_hold: got v/r/c=%b/%0d/%0d want 1/2/3", key_valid, key_row, key_col);
      tests_failed++;
    end
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    tests_run++;
    if ({key_valid, key_row, key_col} !== 5'd0) begin
      $display("FAIL press_accept: got v/r/c=%b/%0d/%0d want 0/0/0", key_valid, key_row, key_col);
      tests_failed++;
    end
    row_in = 3'b000;
    step(4);
    tests_run++;
    if (col_drv !== 3'b100) begin
      $display("FAIL release_hold: got col=%b want 100", col_drv);
      tests_failed++;
    end
    step(1);
    tests_run++;
    if (col_drv !== 3'b001) begin
      $display("FAIL release_next_col: got col=%b want 001", col_drv);
      tests_failed++;
    end
  endtask

  task automatic test_bounce();
    bit early = 1'b0;
    wait_col(3'b100);
    row_in = 3'b010;
    step(4);
    row_in = 3'b000;
    step(1);
    tests_run++;
    if (key_valid !== 1'b0 || col_drv !== 3'b100) begin
      $display("FAIL bounce_abort: got v=%b col=%b want 0/100", key_valid, col_drv);
      tests_failed++;
    end
    step(1);
    tests_run++;
    if (col_drv !== 3'b100) begin
      $display("FAIL bounce_redwell: got col=%b want 100", col_drv);
      tests_failed++;
    end
    step(1);
    tests_run++;
    if (col_drv !== 3'b001 || key_valid !== 1'b0) begin
      $display("FAIL bounce_advance: got col=%b v=%b want 001/0", col_drv, key_valid);
      tests_failed++;
    end
    wait_col(3'b100);
    row_in = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (key_valid !== 1'b0) early = 1'b1;
    end
    step(1);
    tests_run++;
    if (early || {key_valid, key_row, key_col} !== {1'b1, 2'd2, 2'd3}) begin
      $display("FAIL bounce_press: got early=%b v/r/c=%b/%0d/%0d want 0 1/2/3", early, key_valid, key_row, key_col);
      tests_failed++;
    end
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    row_in = 3'b000;
    step(5);
    tests_run++;
    if (key_valid !== 1'b0 || col_drv !== 3'b001 || overrun !== 1'b0) begin
      $display("FAIL bounce_single: got v=%b col=%b o=%b want 0/001/0", key_valid, col_drv, overrun);
      tests_failed++;
    end
  endtask

  task automatic test_multi_row();
    wait_col(3'b001);
    row_in = 3'b101;
    step(6);
    tests_run++;
    if ({key_valid, key_row, key_col} !== {1'b1, 2'd3, 2'd1}) begin
      $display("FAIL multi_row: got v/r/c=%b/%0d/%0d want 1/3/1", key_valid, key_row, key_col);
      tests_failed++;
    end
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    row_in = 3'b000;
    step(5);
  endtask

  task automatic test_overrun();
    wait_col(3'b001);
    row_in = 3'b001;
    step(6);
    tests_run++;
    if ({key_valid, key_row, key_col} !== {1'b1, 2'd1, 2'd1}) begin
      $display("FAIL ovr_first: got v/r/c=%b/%0d/%0d want 1/1/1", key_valid, key_row, key_col);
      tests_failed++;
    end
    row_in = 3'b000;
    step(5);
    tests_run++;
    if (col_drv !== 3'b010 || overrun !== 1'b0) begin
      $display("FAIL ovr_release: got col=%b o=%b want 010/0", col_drv, overrun);
      tests_failed++;
    end
    row_in = 3'b100;
    step(6);
    tests_run++;
    if ({overrun, key_valid, key_row, key_col} !== {1'b1, 1'b1, 2'd1, 2'd1}) begin
      $display("FAIL ovr_set: got o/v/r/c=%b/%b/%0d/%0d want 1/1/1/1", overrun, key_valid, key_row, key_col);
      tests_failed++;
    end
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    tests_run++;
    if ({overrun, key_valid, key_row, key_col} !== {1'b0, 1'b1, 2'd1, 2'd1}) begin
      $display("FAIL ovr_clear: got o/v/r/c=%b/%b/%0d/%0d want 0/1/1/1", overrun, key_valid, key_row, key_col);
      tests_failed++;
    end
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    row_in = 3'b000;
    step(5);
    tests_run++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      $display("FAIL ovr_single_delivery: got v=%b o=%b want 0/0", key_valid, overrun);
      tests_failed++;
    end
  endtask

  task automatic test_en_reset();
    wait_col(3'b001);
    row_in = 3'b001;
    step(6);
    row_in = 3'b000;
    step(5);
    row_in = 3'b010;
    step(4);
    en = 1'b0;
    step(1);
    tests_run++;
    if ({col_drv, key_valid, key_row, key_col, overrun} !== {3'b000, 1'b1, 2'd1, 2'd1, 1'b0}) begin
      $display("FAIL en_drop: got col/v/r/c/o=%b/%b/%0d/%0d/%b want 000/1/1/1/0",
               col_drv, key_valid, key_row, key_col, overrun);
      tests_failed++;
    end
    step(2);
    tests_run++;
    if (col_drv !== 3'b000 || key_valid !== 1'b1) begin
      $display("FAIL en_idle: got col=%b v=%b want 000/1", col_drv, key_valid);
      tests_failed++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({col_drv, key_valid, key_row, key_col, overrun} !== 9'd0) begin
      $display("FAIL async_reset: got col/v/r/c/o=%b/%b/%0d/%0d/%b want all 0",
               col_drv, key_valid, key_row, key_col, overrun);
      tests_failed++;
    end
    row_in = 3'b000;
    en = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    tests_run++;
    if (col_drv !== 3'b001 || key_valid !== 1'b0) begin
      $display("FAIL reset_restart: got col=%b v=%b want 001/0", col_drv, key_valid);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_multi_row();
    test_overrun();
    test_en_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
